// File: rtl/lzma_rc_pkg.sv
// Shared types and constants for the LZMA range-coder output stage.
// Used by rc_byte_emitter (optional RC_LEADING_ZERO_EN build macro lives there).
package lzma_rc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CACHE,
        ST_RUN,
        ST_TAIL
    } rc_state_e;

    localparam logic [7:0] RC_FF_BYTE = 8'hFF;

    // A pending 0xFF byte becomes 0x00 when a carry ripples through it.
    function automatic logic [7:0] run_byte(input logic carry);
        return carry ? 8'h00 : RC_FF_BYTE;
    endfunction

endpackage

// File: rtl/rc_byte_emitter.sv
// Range-coder carry resolution: holds one cache byte plus a count of pending 0xFF bytes.
// Build macro RC_LEADING_ZERO_EN makes every stream start with the standard 0x00 byte.
module rc_byte_emitter
    import lzma_rc_pkg::*;
#(
    parameter int CW = 16
) (
    input  logic       clk,
    input  logic       rstn,
    output logic       i_rdy,
    input  logic       i_en,
    input  logic [7:0] i_byte,
    input  logic       i_carry,
    input  logic       i_last,
    input  logic       o_rdy,
    output logic       o_en,
    output logic [7:0] o_data,
    output logic       o_last,
    output logic       o_err
);

`ifdef RC_LEADING_ZERO_EN
    localparam logic INIT_HAVE_CACHE = 1'b1;
`else
    localparam logic INIT_HAVE_CACHE = 1'b0;
`endif
    localparam logic [7:0] INIT_CACHE = 8'h00;

    rc_state_e     state, state_n;
    logic [7:0]    cache, cache_n;
    logic          have_cache, have_cache_n;
    logic [CW-1:0] ff_cnt, ff_cnt_n;
    logic [CW-1:0] run_left, run_left_n;
    logic [7:0]    new_byte, new_byte_n;
    logic          carry_q, carry_q_n;
    logic          last_q, last_q_n;
    logic          o_en_n, o_last_n, o_err_n;
    logic [7:0]    o_data_n;
    logic          handshake;
    logic          do_exit;
    logic          absorb;

    assign i_rdy     = (state == ST_IDLE);
    assign handshake = o_en & o_rdy;
    assign absorb    = (i_byte == RC_FF_BYTE) & ~i_carry & ~i_last;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= ST_IDLE;
            cache      <= INIT_CACHE;
            have_cache <= INIT_HAVE_CACHE;
            ff_cnt     <= '0;
            run_left   <= '0;
            new_byte   <= 8'h00;
            carry_q    <= 1'b0;
            last_q     <= 1'b0;
            o_en       <= 1'b0;
            o_data     <= 8'h00;
            o_last     <= 1'b0;
            o_err      <= 1'b0;
        end else begin
            state      <= state_n;
            cache      <= cache_n;
            have_cache <= have_cache_n;
            ff_cnt     <= ff_cnt_n;
            run_left   <= run_left_n;
            new_byte   <= new_byte_n;
            carry_q    <= carry_q_n;
            last_q     <= last_q_n;
            o_en       <= o_en_n;
            o_data     <= o_data_n;
            o_last     <= o_last_n;
            o_err      <= o_err_n;
        end
    end

    // The output registers always hold the byte being presented, so each
    // transition loads the byte for the state being entered.
    always_comb begin
        state_n      = state;
        cache_n      = cache;
        have_cache_n = have_cache;
        ff_cnt_n     = ff_cnt;
        run_left_n   = run_left;
        new_byte_n   = new_byte;
        carry_q_n    = carry_q;
        last_q_n     = last_q;
        o_en_n       = o_en;
        o_data_n     = o_data;
        o_last_n     = o_last;
        o_err_n      = o_err;
        do_exit      = 1'b0;

        case (state)
            ST_IDLE: begin
                if (i_en) begin
                    if (absorb) begin
                        if (&ff_cnt) begin
                            o_err_n = 1'b1;
                        end else begin
                            ff_cnt_n = ff_cnt + CW'(1);
                        end
                    end else begin
                        new_byte_n = i_byte;
                        last_q_n   = i_last;
                        run_left_n = ff_cnt;
                        ff_cnt_n   = '0;
                        carry_q_n  = i_carry & have_cache;
                        if (i_carry & ~have_cache) begin
                            o_err_n = 1'b1;
                        end
                        if (have_cache) begin
                            state_n  = ST_CACHE;
                            o_en_n   = 1'b1;
                            o_data_n = cache + {7'b0, i_carry};
                            o_last_n = 1'b0;
                        end else if (ff_cnt != '0) begin
                            state_n  = ST_RUN;
                            o_en_n   = 1'b1;
                            o_data_n = run_byte(1'b0);
                            o_last_n = 1'b0;
                        end else begin
                            do_exit = 1'b1;
                        end
                    end
                end
            end

            ST_CACHE: begin
                if (handshake) begin
                    if (run_left != '0) begin
                        state_n  = ST_RUN;
                        o_data_n = run_byte(carry_q);
                    end else begin
                        do_exit = 1'b1;
                    end
                end
            end

            ST_RUN: begin
                if (handshake) begin
                    run_left_n = run_left - CW'(1);
                    if (run_left == CW'(1)) begin
                        do_exit = 1'b1;
                    end
                end
            end

            ST_TAIL: begin
                if (handshake) begin
                    state_n      = ST_IDLE;
                    cache_n      = INIT_CACHE;
                    have_cache_n = INIT_HAVE_CACHE;
                    ff_cnt_n     = '0;
                    o_en_n       = 1'b0;
                    o_last_n     = 1'b0;
                end
            end

            default: begin
                state_n = ST_IDLE;
                o_en_n  = 1'b0;
            end
        endcase

        // Shared exit step: either park the new byte as the cache or flush it as the tail.
        if (do_exit) begin
            if (last_q_n) begin
                state_n  = ST_TAIL;
                o_en_n   = 1'b1;
                o_data_n = new_byte_n;
                o_last_n = 1'b1;
            end else begin
                state_n      = ST_IDLE;
                cache_n      = new_byte_n;
                have_cache_n = 1'b1;
                o_en_n       = 1'b0;
                o_last_n     = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rc_byte_emitter.sv
// Directed bench for rc_byte_emitter; expectations follow the RC_LEADING_ZERO_EN setting.
// A second CW=2 instance shares the stimulus and is used for the counter-overflow check.
module tb_rc_byte_emitter;

`ifdef RC_LEADING_ZERO_EN
    localparam logic LZ = 1'b1;
`else
    localparam logic LZ = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       i_en;
    logic [7:0] i_byte;
    logic       i_carry;
    logic       i_last;
    logic       o_rdy;
    logic       i_rdy, o_en, o_last, o_err;
    logic [7:0] o_data;
    logic       s_i_rdy, s_o_en, s_o_last, s_o_err;
    logic [7:0] s_o_data;

    int errors = 0;
    int checks = 0;

    rc_byte_emitter #(.CW(16)) dut (
        .clk(clk), .rstn(rstn), .i_rdy(i_rdy), .i_en(i_en), .i_byte(i_byte),
        .i_carry(i_carry), .i_last(i_last), .o_rdy(o_rdy), .o_en(o_en),
        .o_data(o_data), .o_last(o_last), .o_err(o_err)
    );

    rc_byte_emitter #(.CW(2)) dut_small (
        .clk(clk), .rstn(rstn), .i_rdy(s_i_rdy), .i_en(i_en), .i_byte(i_byte),
        .i_carry(i_carry), .i_last(i_last), .o_rdy(o_rdy), .o_en(s_o_en),
        .o_data(s_o_data), .o_last(s_o_last), .o_err(s_o_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkValue(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drives one event across a single rising edge; returns at the following falling edge.
    task automatic applyStimulus(input logic [7:0] b, input logic c, input logic l);
        checkValue("i_rdy_before_event", {7'b0, i_rdy}, 8'h01);
        i_en    = 1'b1;
        i_byte  = b;
        i_carry = c;
        i_last  = l;
        @(negedge clk);
        i_en    = 1'b0;
        i_byte  = 8'h00;
        i_carry = 1'b0;
        i_last  = 1'b0;
    endtask

    // Checks what is presented this cycle, then lets one edge pass (o_rdy high consumes it).
    task automatic checkOutput(input string tag, input logic en, input logic [7:0] d, input logic l);
        checkValue({tag, "_en"}, {7'b0, o_en}, {7'b0, en});
        if (en) begin
            checkValue({tag, "_data"}, o_data, d);
            checkValue({tag, "_last"}, {7'b0, o_last}, {7'b0, l});
        end
        @(negedge clk);
    endtask

    task automatic doReset();
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        rstn    = 1'b0;
        i_en    = 1'b0;
        i_byte  = 8'h00;
        i_carry = 1'b0;
        i_last  = 1'b0;
        o_rdy   = 1'b1;
        @(negedge clk);
        doReset();

        $display("[TB] reset state");
        checkValue("rst_i_rdy", {7'b0, i_rdy}, 8'h01);
        checkValue("rst_o_en", {7'b0, o_en}, 8'h00);
        checkValue("rst_o_data", o_data, 8'h00);
        checkValue("rst_o_last", {7'b0, o_last}, 8'h00);
        checkValue("rst_o_err", {7'b0, o_err}, 8'h00);
        checkValue("rst_s_i_rdy", {7'b0, s_i_rdy}, 8'h01);
        checkValue("rst_s_o_en", {7'b0, s_o_en}, 8'h00);
        checkValue("rst_s_o_data", s_o_data, 8'h00);
        checkValue("rst_s_o_last", {7'b0, s_o_last}, 8'h00);

        $display("[TB] leading zero");
        applyStimulus(8'h12, 1'b0, 1'b0);
        checkOutput("lz_first", LZ, 8'h00, 1'b0);
        applyStimulus(8'h34, 1'b0, 1'b0);
        checkOutput("lz_second", 1'b1, 8'h12, 1'b0);
        checkOutput("lz_done", 1'b0, 8'h00, 1'b0);

        $display("[TB] carry through run");
        doReset();
        applyStimulus(8'h12, 1'b0, 1'b0);
        checkOutput("cr_lead", LZ, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hFF, 1'b0, 1'b0);
            checkValue("cr_absorb_quiet", {7'b0, o_en}, 8'h00);
        end
        applyStimulus(8'h40, 1'b1, 1'b0);
        checkOutput("cr_cache", 1'b1, 8'h13, 1'b0);
        checkOutput("cr_run0", 1'b1, 8'h00, 1'b0);
        checkOutput("cr_run1", 1'b1, 8'h00, 1'b0);
        checkOutput("cr_run2", 1'b1, 8'h00, 1'b0);
        checkOutput("cr_done", 1'b0, 8'h00, 1'b0);
        checkValue("cr_no_err", {7'b0, o_err}, 8'h00);

        $display("[TB] run without carry, with backpressure");
        doReset();
        applyStimulus(8'h12, 1'b0, 1'b0);
        checkOutput("bp_lead", LZ, 8'h00, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h05, 1'b0, 1'b0);
        checkOutput("bp_cache", 1'b1, 8'h12, 1'b0);
        o_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checkValue("bp_stall_en", {7'b0, o_en}, 8'h01);
            checkValue("bp_stall_data", o_data, 8'hFF);
            checkValue("bp_stall_i_rdy", {7'b0, i_rdy}, 8'h00);
            @(negedge clk);
        end
        o_rdy = 1'b1;
        checkOutput("bp_run0", 1'b1, 8'hFF, 1'b0);
        checkOutput("bp_run1", 1'b1, 8'hFF, 1'b0);
        checkOutput("bp_done", 1'b0, 8'h00, 1'b0);
        applyStimulus(8'h33, 1'b0, 1'b1);
        checkOutput("bp_held_cache", 1'b1, 8'h05, 1'b0);
        checkOutput("bp_tail", 1'b1, 8'h33, 1'b1);
        checkOutput("bp_tail_done", 1'b0, 8'h00, 1'b0);

        $display("[TB] last event");
        doReset();
        applyStimulus(8'h12, 1'b0, 1'b0);
        checkOutput("le_lead", LZ, 8'h00, 1'b0);
        applyStimulus(8'hAB, 1'b0, 1'b1);
        checkOutput("le_cache", 1'b1, 8'h12, 1'b0);
        checkOutput("le_tail", 1'b1, 8'hAB, 1'b1);
        checkOutput("le_done", 1'b0, 8'h00, 1'b0);
        applyStimulus(8'h77, 1'b0, 1'b0);
        checkOutput("le_restart", LZ, 8'h00, 1'b0);

        $display("[TB] carry with no cache");
        doReset();
        applyStimulus(8'h50, 1'b1, 1'b0);
        checkValue("nc_err", {7'b0, o_err}, {7'b0, ~LZ});
        checkOutput("nc_out", LZ, 8'h01, 1'b0);

        $display("[TB] counter overflow and reset mid-run");
        doReset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(8'hFF, 1'b0, 1'b0);
        end
        checkValue("ov_err_before", {7'b0, s_o_err}, 8'h00);
        applyStimulus(8'hFF, 1'b0, 1'b0);
        checkValue("ov_err_after", {7'b0, s_o_err}, 8'h01);
        checkValue("ov_main_no_err", {7'b0, o_err}, 8'h00);
        applyStimulus(8'h05, 1'b0, 1'b0);
        checkValue("mr_busy", {7'b0, o_en}, 8'h01);
        @(negedge clk);
        checkValue("mr_in_run", o_data, 8'hFF);
        rstn = 1'b0;
        @(negedge clk);
        checkValue("mr_o_en", {7'b0, o_en}, 8'h00);
        checkValue("mr_o_err", {7'b0, o_err}, 8'h00);
        checkValue("mr_i_rdy", {7'b0, i_rdy}, 8'h01);
        checkValue("mr_o_data", o_data, 8'h00);
        checkValue("mr_s_o_err", {7'b0, s_o_err}, 8'h00);
        rstn = 1'b1;
        @(negedge clk);
        checkValue("mr_still_idle", {7'b0, o_en}, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
